// File: rtl/nclic_pkg.sv
// rtl/nclic_pkg.sv - shared types and sizing for the n_clic dispatch stage
package nclic_pkg;

   localparam int INT_AMOUNT = 8;
   localparam int PRIORITIES = 4;
   localparam int IDX_W      = $clog2(INT_AMOUNT);
   localparam int PRIO_W     = $clog2(PRIORITIES);

   typedef logic [IDX_W-1:0]  int_index_t;
   typedef logic [PRIO_W-1:0] int_priority_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_REQ  = 1'b1
   } dispatch_state_t;

   function automatic int depth_w(input int stack_depth);
      return $clog2(stack_depth + 1);
   endfunction

endpackage

// File: rtl/nclic_prio_stack.sv
// rtl/nclic_prio_stack.sv - running-priority register plus LIFO of preempted priorities
module nclic_prio_stack
   import nclic_pkg::*;
#(
   parameter int DEPTH   = PRIORITIES - 1,
   parameter int DEPTH_W = depth_w(DEPTH)
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               push,
   input  logic               pop,
   input  logic               replace,
   input  logic [PRIO_W-1:0]  din,
   output logic [PRIO_W-1:0]  top,
   output logic [DEPTH_W-1:0] depth
);

   // top is the live threshold; mem holds the thresholds it displaced
   int_priority_t mem [1 << DEPTH_W];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         top   <= '0;
         depth <= '0;
         for (int i = 0; i < (1 << DEPTH_W); i++) begin
            mem[i] <= '0;
         end
      end else if (push && depth < DEPTH_W'(DEPTH)) begin
         mem[depth] <= top;
         top        <= din;
         depth      <= depth + 1'b1;
      end else if (pop && depth != '0) begin
         top   <= mem[depth - 1'b1];
         depth <= depth - 1'b1;
      end else if (replace) begin
         top <= din;
      end
   end

endmodule

// File: rtl/nclic_dispatch.sv
// rtl/nclic_dispatch.sv - threshold gate, core request handshake and pending clear for n_clic
module nclic_dispatch
   import nclic_pkg::*;
#(
   parameter int STACK_DEPTH = PRIORITIES - 1,
   parameter int DEPTH_W     = depth_w(STACK_DEPTH)
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               i_int,
   input  logic [IDX_W-1:0]   i_idx,
   input  logic [PRIO_W-1:0]  i_prio,
   output logic               o_irq_req,
   output logic [IDX_W-1:0]   o_irq_idx,
   output logic [PRIO_W-1:0]  o_irq_prio,
   input  logic               i_irq_ack,
   input  logic               i_mret,
   output logic               o_clear_pending,
   output logic [IDX_W-1:0]   o_clear_idx,
   output logic [PRIO_W-1:0]  o_threshold,
   output logic [DEPTH_W-1:0] o_depth,
   output logic               o_err,
   input  logic               i_err_clr
);

   dispatch_state_t state;
   logic ack, take, push, pop, replace, underflow;

   always_comb begin
      ack       = (state == ST_REQ) && i_irq_ack;
      take      = (state == ST_IDLE) && i_int && (i_prio > o_threshold)
                  && (o_depth < DEPTH_W'(STACK_DEPTH));
      // ack together with mret is a tail-chain: swap the threshold in place
      push      = ack && !i_mret;
      replace   = ack && i_mret;
      pop       = !ack && i_mret;
      underflow = pop && (o_depth == '0);
   end

   nclic_prio_stack #(
      .DEPTH   (STACK_DEPTH),
      .DEPTH_W (DEPTH_W)
   ) u_stack (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (push),
      .pop     (pop),
      .replace (replace),
      .din     (o_irq_prio),
      .top     (o_threshold),
      .depth   (o_depth)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state           <= ST_IDLE;
         o_irq_req       <= 1'b0;
         o_irq_idx       <= '0;
         o_irq_prio      <= '0;
         o_clear_pending <= 1'b0;
         o_clear_idx     <= '0;
         o_err           <= 1'b0;
      end else begin
         o_clear_pending <= ack;
         if (ack) begin
            o_clear_idx <= o_irq_idx;
         end
         if (underflow) begin
            o_err <= 1'b1;
         end else if (i_err_clr) begin
            o_err <= 1'b0;
         end
         case (state)
            ST_IDLE: begin
               if (take) begin
                  state      <= ST_REQ;
                  o_irq_req  <= 1'b1;
                  o_irq_idx  <= i_idx;
                  o_irq_prio <= i_prio;
               end
            end
            ST_REQ: begin
               if (i_irq_ack) begin
                  state     <= ST_IDLE;
                  o_irq_req <= 1'b0;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_nclic_dispatch.sv
// tb/tb_nclic_dispatch.sv - checks two dispatch instances (nesting limits 3 and 2) against a reference model
module tb_nclic_dispatch;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       i_int;
   logic [2:0] i_idx;
   logic [1:0] i_prio;
   logic       i_irq_ack, i_mret, i_err_clr;

   logic       req  [2];
   logic [2:0] ridx [2];
   logic [1:0] rprio[2];
   logic       clr  [2];
   logic [2:0] cidx [2];
   logic [1:0] thr  [2];
   logic [1:0] dep  [2];
   logic       err  [2];

   int errors = 0;
   int checks = 0;

   int m_sd [2] = '{3, 2};
   bit m_req[2];
   int m_idx[2];
   int m_prio[2];
   int m_thr[2];
   int m_dep[2];
   int m_stk[2][4];
   bit m_clr[2];
   int m_cidx[2];
   bit m_err[2];

   always #5 clk = ~clk;

   nclic_dispatch dut0 (
      .clk(clk), .reset_n(reset_n), .i_int(i_int), .i_idx(i_idx), .i_prio(i_prio),
      .o_irq_req(req[0]), .o_irq_idx(ridx[0]), .o_irq_prio(rprio[0]),
      .i_irq_ack(i_irq_ack), .i_mret(i_mret),
      .o_clear_pending(clr[0]), .o_clear_idx(cidx[0]),
      .o_threshold(thr[0]), .o_depth(dep[0]), .o_err(err[0]), .i_err_clr(i_err_clr)
   );

   nclic_dispatch #(.STACK_DEPTH(2)) dut1 (
      .clk(clk), .reset_n(reset_n), .i_int(i_int), .i_idx(i_idx), .i_prio(i_prio),
      .o_irq_req(req[1]), .o_irq_idx(ridx[1]), .o_irq_prio(rprio[1]),
      .i_irq_ack(i_irq_ack), .i_mret(i_mret),
      .o_clear_pending(clr[1]), .o_clear_idx(cidx[1]),
      .o_threshold(thr[1]), .o_depth(dep[1]), .o_err(err[1]), .i_err_clr(i_err_clr)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_req[k] = 0; m_idx[k] = 0; m_prio[k] = 0; m_thr[k] = 0;
         m_dep[k] = 0; m_clr[k] = 0; m_cidx[k] = 0; m_err[k] = 0;
      end
   endtask

   task automatic model_step();
      for (int k = 0; k < 2; k++) begin
         bit take, ack, eset;
         take = !m_req[k] && i_int && (int'(i_prio) > m_thr[k]) && (m_dep[k] < m_sd[k]);
         ack  = m_req[k] && i_irq_ack;
         eset = 0;
         m_clr[k] = ack;
         if (ack) begin
            m_cidx[k] = m_idx[k];
            if (!i_mret) begin
               m_stk[k][m_dep[k]] = m_thr[k];
               m_dep[k]++;
            end
            m_thr[k] = m_prio[k];
            m_req[k] = 0;
         end else if (i_mret) begin
            if (m_dep[k] > 0) begin
               m_dep[k]--;
               m_thr[k] = m_stk[k][m_dep[k]];
            end else begin
               eset = 1;
            end
         end
         if (eset) m_err[k] = 1;
         else if (i_err_clr) m_err[k] = 0;
         if (take) begin
            m_req[k]  = 1;
            m_idx[k]  = int'(i_idx);
            m_prio[k] = int'(i_prio);
         end
      end
   endtask

   task automatic check_all();
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("req%0d", k), req[k], m_req[k]);
         if (m_req[k]) begin
            chk($sformatf("irq_idx%0d", k), ridx[k], m_idx[k]);
            chk($sformatf("irq_prio%0d", k), rprio[k], m_prio[k]);
         end
         chk($sformatf("clear%0d", k), clr[k], m_clr[k]);
         if (m_clr[k]) chk($sformatf("clear_idx%0d", k), cidx[k], m_cidx[k]);
         chk($sformatf("threshold%0d", k), thr[k], m_thr[k]);
         chk($sformatf("depth%0d", k), dep[k], m_dep[k]);
         chk($sformatf("err%0d", k), err[k], m_err[k]);
      end
   endtask

   task automatic step(input bit a_int, input int a_idx, input int a_prio,
                       input bit a_ack, input bit a_mret, input bit a_clr);
      i_int = a_int; i_idx = 3'(a_idx); i_prio = 2'(a_prio);
      i_irq_ack = a_ack; i_mret = a_mret; i_err_clr = a_clr;
      @(posedge clk);
      model_step();
      #1;
      check_all();
   endtask

   initial begin
      reset_n = 1'b0;
      i_int = 0; i_idx = 0; i_prio = 0; i_irq_ack = 0; i_mret = 0; i_err_clr = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all();
      reset_n = 1'b1;

      // basic request, ack, clear pulse, no re-request of the same line
      step(0, 0, 0, 0, 0, 0);
      step(1, 5, 2, 0, 0, 0);
      chk("p1_req", req[0], 1); chk("p1_idx", ridx[0], 5); chk("p1_prio", rprio[0], 2);
      step(1, 5, 2, 0, 0, 0);
      step(1, 5, 2, 1, 0, 0);
      chk("p1_req_drop", req[0], 0); chk("p1_clr", clr[0], 1); chk("p1_clr_idx", cidx[0], 5);
      chk("p1_thr", thr[0], 2); chk("p1_dep", dep[0], 1);
      for (int i = 0; i < 4; i++) begin
         step(1, 5, 2, 0, 0, 0);
         chk("p1_no_rereq", req[0], 0);
      end

      // threshold gating and nested pops
      step(1, 3, 2, 0, 0, 0);
      step(1, 3, 1, 0, 0, 0);
      chk("p2_below_thr", req[0], 0);
      step(1, 2, 3, 0, 0, 0);
      chk("p2_req", req[0], 1);
      step(1, 2, 3, 1, 0, 0);
      chk("p2_thr3", thr[0], 3); chk("p2_dep2", dep[0], 2);
      step(0, 0, 0, 0, 1, 0);
      chk("p2_pop_thr", thr[0], 2); chk("p2_pop_dep", dep[0], 1);
      step(0, 0, 0, 0, 1, 0);
      chk("p2_pop2_thr", thr[0], 0); chk("p2_pop2_dep", dep[0], 0);

      // request stays stable while the arbiter output changes
      step(1, 4, 1, 0, 0, 0);
      step(1, 2, 3, 0, 0, 0);
      step(1, 2, 3, 0, 0, 0);
      chk("p3_hold_idx", ridx[0], 4); chk("p3_hold_prio", rprio[0], 1);
      step(1, 2, 3, 1, 0, 0);
      chk("p3_ack_req", req[0], 0);
      step(1, 2, 3, 0, 0, 0);
      chk("p3_next_req", req[0], 1); chk("p3_next_prio", rprio[0], 3);
      step(0, 0, 0, 1, 0, 0);
      step(0, 0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 1, 0);

      // tail-chain
      step(1, 1, 2, 0, 0, 0);
      step(1, 1, 2, 1, 0, 0);
      step(1, 6, 3, 0, 0, 0);
      step(1, 6, 3, 1, 1, 0);
      chk("p4_dep", dep[0], 1); chk("p4_thr", thr[0], 3); chk("p4_clr", clr[0], 1);
      step(0, 0, 0, 0, 1, 0);
      chk("p4_top_thr", thr[0], 0); chk("p4_top_dep", dep[0], 0);

      // underflow error, clear, depth-full gate on the depth-2 instance
      step(0, 0, 0, 0, 1, 0);
      chk("p5_err", err[0], 1); chk("p5_dep", dep[0], 0);
      step(0, 0, 0, 0, 0, 1);
      chk("p5_err_clr", err[0], 0);
      step(1, 1, 1, 0, 0, 0);
      step(1, 1, 1, 1, 0, 0);
      step(1, 2, 2, 0, 0, 0);
      step(1, 2, 2, 1, 0, 0);
      step(1, 7, 3, 0, 0, 0);
      chk("p5_full_gate", req[1], 0); chk("p5_not_full", req[0], 1);
      step(1, 7, 3, 0, 0, 0);
      chk("p5_full_gate2", req[1], 0);

      // asynchronous reset mid-request
      #2;
      reset_n = 1'b0;
      #1;
      chk("p6_req", req[0], 0); chk("p6_thr", thr[0], 0); chk("p6_dep", dep[0], 0);
      model_reset();
      check_all();
      #2;
      reset_n = 1'b1;

      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 3) != 0, int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
              $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
